rgb_fade_sequencer: RTL

- Upstream neighbour of rgb_pipelined_pwm: generates its r_target/g_target/b_target duty values.
- Accepts colour commands over a valid/ready handshake and buffers them in a small FIFO.
- Executes each command in order, ramping all three targets toward the commanded colour by a bounded step on every fade tick.
- Signals completion of each command with a one-cycle fade_done pulse.

---
 rtl/rgb_pwm_pkg.sv | 18 +
 rtl/rgb_cmd_fifo.sv | 54 +++++
 rtl/rgb_fade_sequencer.sv | 135 +++++++++++++
 3 files changed

// File: rtl/rgb_pwm_pkg.sv
// Shared types for the RGB fade sequencer and its PWM neighbour.
package rgb_pwm_pkg;

    localparam int DEFAULT_W = 64;

    typedef struct packed {
        logic [DEFAULT_W-1:0] r;
        logic [DEFAULT_W-1:0] g;
        logic [DEFAULT_W-1:0] b;
        logic [DEFAULT_W-1:0] step;
    } rgb_cmd_t;

    typedef enum logic {
        IDLE = 1'b0,
        FADE = 1'b1
    } fade_state_e;

endpackage

// File: rtl/rgb_cmd_fifo.sv
// Small synchronous command FIFO; head entry is presented combinationally from storage.
module rgb_cmd_fifo
    import rgb_pwm_pkg::*;
#(
    parameter type cmd_t = rgb_cmd_t,
    parameter int  DEPTH = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic push,
    input  cmd_t wr_data,
    input  logic pop,
    output cmd_t rd_data,
    output logic full,
    output logic empty
);

    localparam int AW = $clog2(DEPTH);

    cmd_t           mem [DEPTH];
    logic [AW-1:0]  wr_ptr;
    logic [AW-1:0]  rd_ptr;
    logic [AW:0]    count;
    logic           do_push;
    logic           do_pop;

    assign full    = (count == (AW+1)'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign rd_data = mem[rd_ptr];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: count <= count;
            endcase
        end
    end

    // Storage needs no reset: an entry is only read after it has been written.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= wr_data;
    end

endmodule

// File: rtl/rgb_fade_sequencer.sv
// Colour command sequencer: buffers commands and ramps the RGB duty targets
// toward each destination by a bounded step per fade tick.
module rgb_fade_sequencer
    import rgb_pwm_pkg::*;
#(
    parameter int W        = DEFAULT_W,
    parameter int DEPTH    = 4,
    parameter int TICK_DIV = 1024
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         cmd_valid,
    output logic         cmd_ready,
    input  logic [W-1:0] cmd_r,
    input  logic [W-1:0] cmd_g,
    input  logic [W-1:0] cmd_b,
    input  logic [W-1:0] cmd_step,
    output logic [W-1:0] r_target,
    output logic [W-1:0] g_target,
    output logic [W-1:0] b_target,
    output logic         busy,
    output logic         fade_done
);

    typedef struct packed {
        logic [W-1:0] r;
        logic [W-1:0] g;
        logic [W-1:0] b;
        logic [W-1:0] step;
    } wide_cmd_t;

    localparam int            CW        = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [CW-1:0] TICK_LAST = CW'(TICK_DIV - 1);

    wide_cmd_t     push_cmd;
    wide_cmd_t     head;
    logic          full;
    logic          empty;
    logic          pop;
    fade_state_e   state;
    logic [W-1:0]  dest_r;
    logic [W-1:0]  dest_g;
    logic [W-1:0]  dest_b;
    logic [W-1:0]  step_q;
    logic [CW-1:0] tick_cnt;
    logic [W-1:0]  next_r;
    logic [W-1:0]  next_g;
    logic [W-1:0]  next_b;

    // Differences are compared against the step so cur+step is never formed
    // unless it is known to stay below dest.
    function automatic logic [W-1:0] approach(input logic [W-1:0] cur,
                                              input logic [W-1:0] dest,
                                              input logic [W-1:0] step);
        logic [W-1:0] res;
        res = cur;
        if (cur < dest)      res = ((dest - cur) <= step) ? dest : cur + step;
        else if (cur > dest) res = ((cur - dest) <= step) ? dest : cur - step;
        return res;
    endfunction

    assign push_cmd  = '{r: cmd_r, g: cmd_g, b: cmd_b, step: cmd_step};
    assign cmd_ready = !full;
    assign pop       = (state == IDLE) && !empty;
    assign busy      = (state != IDLE) || !empty;
    assign next_r    = approach(r_target, dest_r, step_q);
    assign next_g    = approach(g_target, dest_g, step_q);
    assign next_b    = approach(b_target, dest_b, step_q);

    rgb_cmd_fifo #(
        .cmd_t (wide_cmd_t),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push    (cmd_valid && cmd_ready),
        .wr_data (push_cmd),
        .pop     (pop),
        .rd_data (head),
        .full    (full),
        .empty   (empty)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            r_target  <= '0;
            g_target  <= '0;
            b_target  <= '0;
            dest_r    <= '0;
            dest_g    <= '0;
            dest_b    <= '0;
            step_q    <= '0;
            tick_cnt  <= '0;
            fade_done <= 1'b0;
        end else begin
            fade_done <= 1'b0;
            case (state)
                IDLE: begin
                    if (!empty) begin
                        dest_r   <= head.r;
                        dest_g   <= head.g;
                        dest_b   <= head.b;
                        step_q   <= head.step;
                        tick_cnt <= '0;
                        if (head.step == '0) begin
                            r_target  <= head.r;
                            g_target  <= head.g;
                            b_target  <= head.b;
                            fade_done <= 1'b1;
                        end else begin
                            state <= FADE;
                        end
                    end
                end
                FADE: begin
                    if (tick_cnt == TICK_LAST) begin
                        tick_cnt <= '0;
                        r_target <= next_r;
                        g_target <= next_g;
                        b_target <= next_b;
                        if (next_r == dest_r && next_g == dest_g && next_b == dest_b) begin
                            fade_done <= 1'b1;
                            state     <= IDLE;
                        end
                    end else begin
                        tick_cnt <= tick_cnt + CW'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
